// File: rtl/dmem_store_buffer.sv
// Doubleword data memory with an in-order store buffer draining into a single-port array.
// Define DMEM_FWD_EN for store-to-load forwarding; otherwise loads that hit the buffer stall.
module dmem_store_buffer #(
  parameter int DEPTH_LOG2 = 8,
  parameter int SB_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_we,
  input  logic                        mem_re,
  input  logic [63:0]                 mem_addr,
  input  logic [63:0]                 mem_wdata,
  output logic                        mem_stall,
  output logic [63:0]                 mem_rdata,
  output logic                        mem_rvalid,
  output logic                        drain_valid,
  output logic [DEPTH_LOG2-1:0]       drain_addr,
  output logic [63:0]                 drain_data,
  output logic [$clog2(SB_DEPTH):0]   sb_count
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2-1:0] r_sb_idx  [SB_DEPTH];
  logic [63:0]           r_sb_data [SB_DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic [63:0]           r_mem [WORDS];
  logic [63:0]           r_arr_q;
  logic                  r_rvalid;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic [PTR_W-1:0]      w_slot [SB_DEPTH];
  logic [SB_DEPTH-1:0]   w_match;
  logic                  w_hit;
  logic                  w_full;
  logic                  w_stall;
  logic                  w_load_acc;
  logic                  w_store_acc;
  logic                  w_drain;
  logic                  w_unused;

  assign w_idx    = mem_addr[DEPTH_LOG2+2:3];
  assign w_unused = ^{mem_addr[63:DEPTH_LOG2+3], mem_addr[2:0]};

  // Match comparators walk the buffer by age: position 0 is the oldest live entry.
  genvar gi;
  generate
    for (gi = 0; gi < SB_DEPTH; gi++) begin : g_match
      assign w_slot[gi]  = r_head + PTR_W'(gi);
      assign w_match[gi] = (CNT_W'(gi) < r_count) && (r_sb_idx[w_slot[gi]] == w_idx);
    end
  endgenerate

  assign w_hit  = |w_match;
  assign w_full = (r_count == CNT_W'(SB_DEPTH));

`ifdef DMEM_FWD_EN
  assign w_stall = w_full && (mem_we || mem_re);
`else
  assign w_stall = (w_full && (mem_we || mem_re)) || (mem_re && w_hit);
`endif

  assign w_load_acc  = mem_re && !w_stall;
  assign w_store_acc = mem_we && !w_stall;
  // A load owns the array port unless the buffer is full; the full case stalls the load anyway.
  assign w_drain     = !rst && (r_count != '0) && (!w_load_acc || w_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_store_acc) r_tail <= r_tail + 1'b1;
      if (w_drain)     r_head <= r_head + 1'b1;
      r_count <= r_count + CNT_W'(w_store_acc) - CNT_W'(w_drain);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_store_acc) begin
      r_sb_idx[r_tail]  <= w_idx;
      r_sb_data[r_tail] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_drain) r_mem[r_sb_idx[r_head]] <= r_sb_data[r_head];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_arr_q  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_load_acc;
      if (w_load_acc) r_arr_q <= r_mem[w_idx];
    end
  end

`ifdef DMEM_FWD_EN
  logic [63:0] w_fwd_data;
  logic        r_fwd_sel;
  logic [63:0] r_fwd_data;

  // Later (younger) matches override earlier ones.
  always_comb begin
    w_fwd_data = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (w_match[k]) w_fwd_data = r_sb_data[w_slot[k]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_sel  <= 1'b0;
      r_fwd_data <= '0;
    end else if (w_load_acc) begin
      r_fwd_sel  <= w_hit;
      r_fwd_data <= w_fwd_data;
    end
  end

  assign mem_rdata = r_fwd_sel ? r_fwd_data : r_arr_q;
`else
  assign mem_rdata = r_arr_q;
`endif

  assign mem_stall   = w_stall;
  assign mem_rvalid  = r_rvalid;
  assign drain_valid = w_drain;
  assign drain_addr  = w_drain ? r_sb_idx[r_head]  : '0;
  assign drain_data  = w_drain ? r_sb_data[r_head] : '0;
  assign sb_count    = r_count;

endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Data-memory responder for the pipelined RV64 core's memory stage: accepts doubleword stores and loads from the core's M stage and returns load data one cycle later. Stores enter a small in-order store buffer and drain into a single-port storage array on cycles when no load needs the array port. A drain-side strobe lets the bench log every committed write.

## Interface
- DEPTH_LOG2, 8: array holds 2^DEPTH_LOG2 64-bit doublewords.
- SB_DEPTH, 4: store-buffer entries; power of two, at least 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mem_we  input  1  store request this cycle.
- mem_re  input  1  load request this cycle.
- mem_addr  input  64  byte address; doubleword index = mem_addr[DEPTH_LOG2+2:3].
- mem_wdata  input  64  store data.
- mem_stall  output  1  request not accepted this cycle; core holds the request and retries.
- mem_rdata  output  64  load data, valid when mem_rvalid=1.
- mem_rvalid  output  1  one-cycle pulse, one cycle after an accepted load.
- drain_valid  output  1  one buffer entry was written to the array this cycle.
- drain_addr  output  DEPTH_LOG2  index of the drained entry.
- drain_data  output  64  data of the drained entry.
- sb_count  output  $clog2(SB_DEPTH)+1  current number of buffer entries.

## Operation
- Addressing: mem_addr[2:0] and bits above DEPTH_LOG2+2 are ignored. Out-of-range addresses alias modulo the array size.
- Store buffer: circular FIFO holding {index, data}, with head pointer, tail pointer and count. A store is accepted when mem_we=1 and mem_stall=0, and is enqueued at the tail.
- Drain: the head entry is written to the array and dequeued when count>0 and either no load is accepted this cycle or count==SB_DEPTH. drain_* reflect that write in the same cycle.
- Full: count==SB_DEPTH gives mem_stall=1 for any request (we or re). The drain forced that cycle frees one entry, so the request is accepted on the following cycle.
- Load: a load is accepted when mem_re=1 and mem_stall=0. The array is read that cycle. The result is registered, and mem_rvalid=1 with mem_rdata on the next cycle.
- Forwarding: if a buffer entry matches the load index, mem_rdata returns the data of the youngest matching entry instead of the array data.
- Load and store in the same cycle: both are accepted (if not full). The load sees state before the store; it does not forward from a store enqueued in that same cycle.
- Same-cycle store and drain: enqueue and dequeue both occur and count is unchanged.
- Ordering: the array always reflects stores in program order. Two stores to the same index drain oldest first.

## Timing
- Reset values:
  - count=0; head and tail pointers = 0.
  - mem_rvalid=0, mem_rdata=0.
  - drain_valid=0, drain_addr=0, drain_data=0.
  - mem_stall=0; sb_count=0.
  - Array contents are not reset.
- Reset asserted mid-operation discards all buffered stores and any pending load result. The next cycle shows the reset values.
- Load latency: exactly 1 cycle from acceptance to mem_rvalid.
- Store-to-array latency: at least 1 cycle, at most count+1 cycles while no loads are accepted.
- mem_stall is combinational from count, mem_we, mem_re and buffer contents.
- mem_rdata holds its last value while mem_rvalid=0.

## Configuration
- DMEM_FWD_EN defined: store-to-load forwarding as described above.
- DMEM_FWD_EN undefined:
  - No forwarding comparators on the load data path.
  - A load whose index matches any buffer entry gets mem_stall=1, and drain is allowed that cycle regardless of mem_re.
  - The load stays stalled until no matching entry remains, then reads the array.

## Test plan
- Store then load, no contention: store 0x1122334455667788 to addr 0x40, idle 1 cycle, load 0x40 → mem_rvalid next cycle with 0x1122334455667788. drain_valid fires once with drain_addr=8.
- Forwarding (DMEM_FWD_EN): store 5 to addr 0x8, then loads to addr 0x10 on every cycle. Next, load 0x8 → rdata=5, delivered the cycle after acceptance. Without DMEM_FWD_EN: the load to 0x8 stalls until the drain, then rdata=5.
- Full buffer: SB_DEPTH+1 back-to-back stores (values 1..5 to addr 0x0..0x20) while loads are active every cycle → mem_stall=1 on the fifth store. One forced drain occurs. Array words 0..4 end up holding 1..5 in order.
- Same-index ordering: store 3 then 9 to addr 0x18, then load 0x18 → rdata=9 both before and after both entries drain.
- Simultaneous load and store to addr 0x30 (array holds 7, store data 42) → this load returns 7; the next load returns 42.
- Reset mid-operation: assert rst with 3 entries buffered → sb_count=0 the next cycle, no further drain_valid, and mem_rvalid=0.
